// File: rtl/serial_word_collector_if.sv
// rtl/serial_word_collector_if.sv - serial bit input, word output and status signals of the collector
interface serial_word_collector_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             clr;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic [CNTW-1:0]  word_cnt;

    modport master (
        output bit_in, bit_valid, clr, out_ready,
        input  out_data, out_parity, out_valid, overflow, word_cnt
    );

    modport slave (
        input  bit_in, bit_valid, clr, out_ready,
        output out_data, out_parity, out_valid, overflow, word_cnt
    );
endinterface

// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - packs qualified serial bits LSB-first into parity-tagged words
module serial_word_collector #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_word_collector_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] shreg;

    logic [WIDTH-1:0] data_q;
    logic             parity_q;
    logic             valid_q;
    logic             ovf_q;
    logic [CNTW-1:0]  wcnt_q;

    logic             take;
    logic             complete;
    logic             load;
    logic [WIDTH-1:0] word;

    assign take     = valid_q & bus.out_ready;
    // clr wins over a completing bit, so completion is masked here
    assign complete = bus.bit_valid & ~bus.clr & (state == S_SHIFT) & (cnt == LAST);
    assign load     = complete & (~valid_q | bus.out_ready);
    assign word     = {bus.bit_in, shreg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else if (bus.clr) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (bus.bit_valid) begin
            case (state)
                S_IDLE: begin
                    shreg[0] <= bus.bit_in;
                    cnt      <= CW'(1);
                    state    <= S_SHIFT;
                end
                default: begin
                    if (cnt == LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        shreg[cnt] <= bus.bit_in;
                        cnt        <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            parity_q <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            if (take) begin
                wcnt_q <= wcnt_q + 1'b1;
            end
            // a load on the transfer edge refills the slot with no bubble
            if (load) begin
                data_q   <= word;
                parity_q <= ^word;
                valid_q  <= 1'b1;
            end else if (take) begin
                valid_q <= 1'b0;
            end
            if (bus.clr) begin
                ovf_q <= 1'b0;
            end else if (complete && !load) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_parity = parity_q;
    assign bus.out_valid  = valid_q;
    assign bus.overflow   = ovf_q;
    assign bus.word_cnt   = wcnt_q;
endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - table vectors, corner sequences and transfer scoreboard for serial_word_collector
module tb_serial_word_collector;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_word_collector_if #(.WIDTH(8), .CNTW(8)) bus ();

    serial_word_collector #(.WIDTH(8), .CNTW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] word;
        int         gap_max;
        logic       exp_parity;
    } vec_t;

    vec_t       vecs[8];
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap_max);
        for (int i = 0; i < 8; i++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
            send_bit(w[i]);
        end
    endtask

    task automatic clr_pulse();
        bus.clr       = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        tick();
        bus.clr       = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    // every accepted word is compared against the head of the expected queue
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
            end else begin
                logic [7:0] w;
                w = exp_q.pop_front();
                chk("xfer_data", {24'd0, bus.out_data}, {24'd0, w});
                chk("xfer_parity", {31'd0, bus.out_parity}, {31'd0, ^w});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h4D, 0, 1'b0};
        vecs[1] = '{8'h4D, 3, 1'b0};
        vecs[2] = '{8'hFF, 0, 1'b0};
        vecs[3] = '{8'h01, 1, 1'b1};
        vecs[4] = '{8'h80, 2, 1'b1};
        vecs[5] = '{8'hA5, 1, 1'b0};
        vecs[6] = '{8'h00, 0, 1'b0};
        vecs[7] = '{8'h7E, 3, 1'b0};

        rst           = 1'b1;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.clr       = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_parity", {31'd0, bus.out_parity}, 32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        chk("rst_word_cnt", {24'd0, bus.word_cnt}, 32'd0);
        tick();
        rst = 1'b0;

        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_word(vecs[i].word, vecs[i].gap_max);
            exp_q.push_back(vecs[i].word);
            exp_cnt++;
            @(negedge clk);
            chk("vec_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("vec_data", {24'd0, bus.out_data}, {24'd0, vecs[i].word});
            chk("vec_parity", {31'd0, bus.out_parity}, {31'd0, vecs[i].exp_parity});
            tick();
            chk("vec_valid_fall", {31'd0, bus.out_valid}, 32'd0);
        end
        chk("vec_word_cnt", {24'd0, bus.word_cnt}, exp_cnt);
        chk("vec_overflow", {31'd0, bus.overflow}, 32'd0);

        // held word survives a second completion that has to be dropped
        bus.out_ready = 1'b0;
        send_word(8'h4D, 0);
        exp_q.push_back(8'h4D);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        chk("bp_ovf_before", {31'd0, bus.overflow}, 32'd0);
        send_bit(1'b1);
        @(negedge clk);
        chk("bp_data_held", {24'd0, bus.out_data}, 32'h4D);
        chk("bp_ovf_set", {31'd0, bus.overflow}, 32'd1);
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk("bp_valid_fall", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_word_cnt", {24'd0, bus.word_cnt}, exp_cnt);

        // clr after overflow and a partial word; the bit on the clr edge is ignored
        send_word(8'h4D, 0);
        exp_q.push_back(8'h4D);
        send_word(8'hFF, 0);
        chk("clr_ovf_pre", {31'd0, bus.overflow}, 32'd1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        clr_pulse();
        chk("clr_ovf", {31'd0, bus.overflow}, 32'd0);
        chk("clr_valid_kept", {31'd0, bus.out_valid}, 32'd1);
        chk("clr_data_kept", {24'd0, bus.out_data}, 32'h4D);
        bus.out_ready = 1'b1;
        send_word(8'h01, 0);
        exp_q.push_back(8'h01);
        exp_cnt += 2;
        @(negedge clk);
        chk("clr_next_data", {24'd0, bus.out_data}, 32'h01);
        chk("clr_next_parity", {31'd0, bus.out_parity}, 32'd1);
        tick();

        // clr on the completing edge wins
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        clr_pulse();
        tick();
        chk("clr_beats_complete", {31'd0, bus.out_valid}, 32'd0);
        chk("clr_beats_ovf", {31'd0, bus.overflow}, 32'd0);
        send_word(8'h3C, 0);
        exp_q.push_back(8'h3C);
        exp_cnt++;
        @(negedge clk);
        chk("after_clr_data", {24'd0, bus.out_data}, 32'h3C);
        tick();

        // accept and reload on the same edge
        bus.out_ready = 1'b0;
        send_word(8'h4D, 0);
        exp_q.push_back(8'h4D);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        bus.out_ready = 1'b1;
        send_bit(1'b1);
        bus.out_ready = 1'b0;
        exp_q.push_back(8'hFF);
        @(negedge clk);
        chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b_data", {24'd0, bus.out_data}, 32'hFF);
        chk("b2b_parity", {31'd0, bus.out_parity}, 32'd0);
        chk("b2b_overflow", {31'd0, bus.overflow}, 32'd0);
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_cnt += 2;
        chk("b2b_valid_fall", {31'd0, bus.out_valid}, 32'd0);
        chk("b2b_word_cnt", {24'd0, bus.word_cnt}, exp_cnt);

        // asynchronous reset mid-word
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data", {24'd0, bus.out_data}, 32'd0);
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_parity", {31'd0, bus.out_parity}, 32'd0);
        chk("arst_overflow", {31'd0, bus.overflow}, 32'd0);
        chk("arst_word_cnt", {24'd0, bus.word_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        send_word(8'hA5, 0);
        exp_q.push_back(8'hA5);
        exp_cnt++;
        @(negedge clk);
        chk("arst_next_data", {24'd0, bus.out_data}, 32'hA5);
        chk("arst_next_parity", {31'd0, bus.out_parity}, 32'd0);
        tick();
        chk("arst_next_cnt", {24'd0, bus.word_cnt}, exp_cnt);

        tick();
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
